store_serializer: RTL and testbench
===================================

STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, store request present.
REQ-004 SHALL have port req_ready, output, 1, unit idle and able to accept a request.
REQ-005 SHALL have port size, input, 2, store width: 00 byte, 01 halfword, 10 word; 11 reserved.
REQ-006 SHALL have port addr, input, 32, byte address of the store.
REQ-007 SHALL have port wdata, input, 32, register data, with the low bits significant for narrow stores.
REQ-008 SHALL have port mem_we, output, 1, byte write strobe to the byte-wide data memory.
REQ-009 SHALL have port mem_addr, output, 32, byte address of the current write.
REQ-010 SHALL have port mem_wdata, output, 8, byte being written.
REQ-011 SHALL have port mem_ready, input, 1, memory accepts the byte when mem_we and mem_ready are both high on a rising edge.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last byte is accepted.
REQ-013 SHALL have port err, output, 1, one-cycle pulse for a rejected request.

Function
REQ-014 SHALL narrow wdata into 1, 2 or 4 bytes (the reverse of load sign extension) and write them little-endian, byte k to addr+k, in ascending order, one byte per accepted memory cycle.
REQ-015 SHALL have a state machine with states IDLE, WRITE and FINISH; req_ready SHALL be high only in IDLE.
REQ-016 SHALL accept a request in IDLE when req_valid is high, latch addr, wdata and size, clear the byte counter and go to WRITE.
REQ-017 SHALL assert mem_we in WRITE, starting the cycle after acceptance.
REQ-018 SHALL, in WRITE, hold mem_addr, mem_wdata and mem_we stable while mem_ready is low.
REQ-019 SHALL, in WRITE, increment the counter on each accepted byte, and go to FINISH when the last byte (count = bytes-1) is accepted.
REQ-020 SHALL, in FINISH, assert done for exactly one cycle and then return to IDLE.
REQ-021 SHALL give a minimum latency, with mem_ready held high, of N+1 cycles from acceptance to done for N bytes.
REQ-022 SHALL compute mem_addr = latched addr + counter, modulo 2^32, so that 0xFFFFFFFF wraps to 0x00000000.
REQ-023 SHALL reject size 11: no memory write, err pulses the cycle after acceptance, and the state returns to IDLE.
REQ-024 SHALL ignore req_valid outside IDLE; a new request is sampled only after the return to IDLE.
REQ-025 SHALL hold mem_we, done and err low whenever they are not being asserted.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: state IDLE, counter 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0, req_ready 1.
REQ-027 SHALL abandon a store interrupted by reset mid-operation: bytes already accepted stay written, and no done is given.

Configuration
REQ-028 SHALL support macro STORE_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠00, is rejected as in REQ-023 with no memory write.
- Undefined: misaligned stores are performed byte-wise per REQ-014, and err pulses only for size 11.

Structure
REQ-029 SHALL take from shared package store_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the per-size byte count constants.
REQ-030 SHALL use one combinational sub-module, store_byte_select, to pick byte [counter] of the latched wdata.

Verification
REQ-031 SHALL cover: byte store, addr 0x10, wdata 0xAABBCCDD, mem_ready=1 -> one write of 0xDD to 0x10, done at cycle 2.
REQ-032 SHALL cover: word store, addr 0x20, wdata 0x11223344 -> 0x44, 0x33, 0x22, 0x11 written to 0x20 through 0x23; done at cycle 5.
REQ-033 SHALL cover: halfword 0xBEEF at 0x40 with mem_ready low for 3 cycles on the first byte -> 0xEF held stable, then 0xBE to 0x41, and one done.
REQ-034 SHALL cover: word at 0xFFFFFFFE, macro undefined -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 and 0x00000001; macro defined -> err pulse and no mem_we.
REQ-035 SHALL cover: size 11 -> err pulse only; and rst_n low after the second byte of a word -> all outputs at reset values immediately, and no done.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: shared size encodings, FSM states and per-size byte counts for the store path.
package store_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam int NB_BYTE = 1;
    localparam int NB_HALF = 2;
    localparam int NB_WORD = 4;
    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        return size == SZ_BYTE ? 2'(NB_BYTE - 1) : size == SZ_HALF ? 2'(NB_HALF - 1) : 2'(NB_WORD - 1);
    endfunction
endpackage

// File: rtl/store_byte_select.sv
// store_byte_select: picks byte [idx] of a 32-bit word, little-endian.
module store_byte_select (
    input  logic [31:0] data,
    input  logic [1:0]  idx,
    output logic [7:0]  byte_out
);
    assign byte_out = data[{idx, 3'b000} +: 8];
endmodule

// File: rtl/store_serializer.sv
// store_serializer: splits a byte/halfword/word store into ascending byte writes.
// Define STORE_ALIGN_CHECK_EN to reject misaligned halfword/word stores.
module store_serializer
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    output logic        done,
    output logic        err
);
    state_t      state;
    logic [31:0] base;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic        bad;
    always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
        bad = size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
`else
        bad = size == SZ_RSVD;
`endif
    end
    store_byte_select u_sel (
        .data     (data),
        .idx      (cnt),
        .byte_out (mem_wdata)
    );
    // address and byte follow the latched request, so they stay put while the memory stalls
    assign mem_addr  = base + 32'(cnt);
    assign req_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base   <= '0;
            data   <= '0;
            cnt    <= '0;
            last   <= '0;
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    cnt <= '0;
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        base   <= addr;
                        data   <= wdata;
                        last   <= last_idx(size);
                        mem_we <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: if (mem_ready) begin
                    if (cnt == last) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_serializer.sv
// tb_store_serializer: queue-based reference model with per-cycle compare, plus directed literal cases.
module tb_store_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_ready = 1'b1;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        req_ready, mem_we, done, err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    int checks = 0;
    int passed = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    store_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  q[$];
    wr_t  log_q[$];
    logic m_done = 1'b0;
    logic m_err = 1'b0;

    function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'b11) return 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: a store becomes a queue of byte writes; the head is on the bus until accepted.
    always @(posedge clk or negedge rst_n) begin : model
        logic nd, ne;
        int   n;
        if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            nd = 1'b0;
            ne = 1'b0;
            if (q.size() > 0) begin
                if (mem_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) nd = 1'b1;
                end
            end else if (!m_done && req_valid) begin
                if (is_bad(size, addr)) ne = 1'b1;
                else begin
                    n = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
                    for (int k = 0; k < n; k++) q.push_back({addr + 32'(k), wdata[8*k +: 8]});
                end
            end
            m_done = nd;
            m_err  = ne;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ready) log_q.push_back({mem_addr, mem_wdata});
        if (rst_n && done) done_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0 && !m_done));
            chk("mem_we", 32'(mem_we), 32'(q.size() > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            if (q.size() > 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_wdata", 32'(mem_wdata), 32'(q[0].d));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " req_ready"}, 32'(req_ready), 1);
    endtask

    // Issue one request from a negedge; lat = cycles from acceptance to done/err.
    task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d, output int lat);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        size = s; addr = a; wdata = d; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && !err && lat < 60) begin @(negedge clk); lat++; end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [7:0] d);
        if (idx < log_q.size()) begin
            chk({name, " addr"}, log_q[idx].a, a);
            chk({name, " data"}, 32'(log_q[idx].d), 32'(d));
        end else begin
            chk({name, " present"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int dc;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        log_q.delete();
        issue(2'b00, 32'h10, 32'hAABBCCDD, lat);
        chk("byte latency", 32'(lat), 2);
        chk("byte count", 32'(log_q.size()), 1);
        chk_log("byte w0", 0, 32'h10, 8'hDD);

        @(negedge clk);
        log_q.delete();
        issue(2'b10, 32'h20, 32'h11223344, lat);
        chk("word latency", 32'(lat), 5);
        chk("word count", 32'(log_q.size()), 4);
        chk_log("word w0", 0, 32'h20, 8'h44);
        chk_log("word w1", 1, 32'h21, 8'h33);
        chk_log("word w2", 2, 32'h22, 8'h22);
        chk_log("word w3", 3, 32'h23, 8'h11);

        @(negedge clk);
        log_q.delete();
        dc = done_cnt;
        mem_ready = 1'b0;
        size = 2'b01; addr = 32'h40; wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall we", 32'(mem_we), 1);
            chk("stall addr", mem_addr, 32'h40);
            chk("stall data", 32'(mem_wdata), 32'hEF);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        @(negedge clk);
        chk("half count", 32'(log_q.size()), 2);
        chk_log("half w0", 0, 32'h40, 8'hEF);
        chk_log("half w1", 1, 32'h41, 8'hBE);
        chk("half dones", 32'(done_cnt - dc), 1);

        log_q.delete();
        issue(2'b10, 32'hFFFFFFFE, 32'hA1B2C3D4, lat);
`ifdef STORE_ALIGN_CHECK_EN
        chk("wrap err latency", 32'(lat), 1);
        chk("wrap err flag", 32'(err), 1);
        chk("wrap no writes", 32'(log_q.size()), 0);
`else
        chk("wrap latency", 32'(lat), 5);
        chk_log("wrap w0", 0, 32'hFFFFFFFE, 8'hD4);
        chk_log("wrap w1", 1, 32'hFFFFFFFF, 8'hC3);
        chk_log("wrap w2", 2, 32'h00000000, 8'hB2);
        chk_log("wrap w3", 3, 32'h00000001, 8'hA1);
`endif

        @(negedge clk);
        log_q.delete();
        dc = done_cnt;
        issue(2'b11, 32'h80, 32'h12345678, lat);
        chk("rsvd err latency", 32'(lat), 1);
        chk("rsvd err flag", 32'(err), 1);
        @(negedge clk);
        chk("rsvd err pulse", 32'(err), 0);
        chk("rsvd no writes", 32'(log_q.size()), 0);
        chk("rsvd no done", 32'(done_cnt - dc), 0);

        @(negedge clk);
        log_q.delete();
        size = 2'b10; addr = 32'h100; wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset writes", 32'(log_q.size()), 2);
        dc = done_cnt;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midreset no done", 32'(done_cnt - dc), 0);
        chk("midreset writes kept", 32'(log_q.size()), 2);

        for (int i = 0; i < 600; i++) begin
            req_valid = $urandom_range(0, 1) == 1;
            size      = 2'($urandom_range(0, 3));
            addr      = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            wdata     = $urandom;
            mem_ready = $urandom_range(0, 9) < 7;
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
